axi_stream_slave_mem: RTL and testbench
=======================================

Name: axi_stream_slave_mem

Overview:
- Simplified AXI-style slave that owns an 8-entry x 4-bit register memory.
- Sits directly downstream of the bus master: consumes its AR/AW/W channels and produces its R/B channels.
- Write transactions accept a fixed-length burst of beats into memory starting at the given address.
- Read transactions stream a fixed-length burst back from the given address.

Parameters:
- DATA_W, 4, data beat width.
- ADDR_W, 3, address width; memory depth = 2**ADDR_W.
- BURST_LEN, 8, beats per read or write burst; legal range 1..2**ADDR_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-high (asserted = 1).
- ar_valid  input  1  read address valid.
- ar_ready  output  1  read address ready.
- ar_addr  input  ADDR_W  burst start address for reads.
- r_valid  output  1  read data valid.
- r_ready  input  1  read data ready.
- r_data  output  DATA_W  read data beat.
- aw_valid  input  1  write address valid.
- aw_ready  output  1  write address ready.
- aw_addr  input  ADDR_W  burst start address for writes.
- w_valid  input  1  write data valid.
- w_ready  output  1  write data ready.
- w_data  input  DATA_W  write data beat.
- b_valid  output  1  write response valid.
- b_ready  input  1  write response ready.

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid & ready are both 1. Nothing else counts as a beat.
- State machine with four states:
  - IDLE.
  - RD_DATA.
  - WR_DATA.
  - WR_RESP.
- Readies and valids are decoded combinationally from the registered state:
  - ar_ready = (state==IDLE).
  - aw_ready = (state==IDLE) & ~ar_valid.
  - r_valid = (state==RD_DATA).
  - w_ready = (state==WR_DATA).
  - b_valid = (state==WR_RESP).
- IDLE transitions:
  - ar handshake: ptr <= ar_addr, cnt <= 0, go to RD_DATA.
  - Otherwise aw handshake: ptr <= aw_addr, cnt <= 0, go to WR_DATA.
  - Simultaneous ar_valid and aw_valid: read wins and the write waits in IDLE.
- RD_DATA:
  - r_data = mem[ptr], combinational, stable while r_valid & ~r_ready.
  - Each r handshake: ptr <= ptr+1 (wraps modulo 2**ADDR_W, 7->0), cnt <= cnt+1.
  - The handshake with cnt==BURST_LEN-1 returns the FSM to IDLE.
- WR_DATA:
  - Each w handshake: mem[ptr] <= w_data, ptr <= ptr+1 (same wrap), cnt <= cnt+1.
  - The handshake with cnt==BURST_LEN-1 moves the FSM to WR_RESP.
- WR_RESP: b_valid held at 1 until b_ready is seen, then IDLE. b_ready in any other state is ignored.
- Latency:
  - Address accepted at edge N gives the first r_valid/w_ready in cycle N+1.
  - Last beat at edge M gives b_valid in cycle M+1, or ar_ready/aw_ready = 1 in cycle M+1 for reads.
- Back-pressure: stalls of any length on r_ready or w_valid are legal. ptr and cnt change only on handshakes.
- cnt width: $clog2(BURST_LEN+1) bits. ptr is ADDR_W bits and wraps naturally.
- Reset (rst_n=1 at an edge), including mid-burst:
  - state <= IDLE, ptr <= 0, cnt <= 0, all mem entries <= 0.
  - Outputs in the following cycle: ar_ready=1, aw_ready=~ar_valid, r_valid=0, w_ready=0, b_valid=0, r_data = mem[0] = 0.
  - An aborted write produces no b_valid.
- Memory is read and written only through this FSM. There is no concurrent read/write, so no collision case exists.

Optional Feature:
- Macro SLV_BURST_CNT_EN.
- When defined:
  - Adds output wr_burst_cnt [7:0].
  - It increments by 1 on each b handshake and saturates at 255.
  - Reset value is 0.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - The state typedef/localparams: IDLE=2'd0, RD_DATA=2'd1, WR_DATA=2'd2, WR_RESP=2'd3.
  - DATA_W, ADDR_W, BURST_LEN defaults, used by this block and the master.
- One natural sub-module: slv_regfile, the 2**ADDR_W x DATA_W memory with synchronous write, combinational read and synchronous clear on reset. The FSM and pointers stay in the top.

Test Plan:
- Reset then idle: after rst_n pulse, ar_ready=1, aw_ready=1, r_valid=w_ready=b_valid=0. Read burst from addr 0 returns eight 4'h0.
- Write burst: aw_addr=0, then w_data 1,3,5,7,9,11,13,15 with w_valid constant -> b_valid one cycle after 8th beat. Read from addr 0 returns 1,3,...,15 in order.
- Wrap-around: write 0,2,...,14 from aw_addr=5 -> mem[5..7]=0,2,4, mem[0..4]=6..14. Read from 5 returns 0,2,...,14.
- Back-pressure: during read, r_ready toggles 1,0,0,1 -> r_data holds during stalls. Exactly 8 beats are delivered, with no skip or repeat.
- Arbitration: ar_valid and aw_valid both 1 in IDLE -> read burst is serviced first, aw_ready=0 meanwhile. The write is accepted on the first IDLE cycle after the read burst.
- Reset mid-write after 3 beats: mem all zeros, no b_valid. With SLV_BURST_CNT_EN, wr_burst_cnt=0, and it reaches 2 after two complete writes.

Source files
------------

// File: rtl/axi_stream_slave_mem_pkg.sv
// Shared types and default sizing for the AXI-style slave memory and its master.
package axi_stream_slave_mem_pkg;

  localparam int DEF_DATA_W    = 4;
  localparam int DEF_ADDR_W    = 3;
  localparam int DEF_BURST_LEN = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_DATA = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/axi_stream_slave_mem_if.sv
// AR/R/AW/W/B channel bundle between the bus master and the slave memory.
interface axi_stream_slave_mem_if
  import axi_stream_slave_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic              b_valid;
  logic              b_ready;

  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
    input  ar_ready, r_valid, r_data, aw_ready, w_ready, b_valid
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
    output ar_ready, r_valid, r_data, aw_ready, w_ready, b_valid
  );
endinterface

// File: rtl/axi_stream_slave_mem_slv_regfile.sv
// 2**ADDR_W x DATA_W register memory: synchronous write/clear, combinational read.
module slv_regfile #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/axi_stream_slave_mem.sv
// AXI-style slave owning a small register memory; fixed-length read/write bursts.
// Optional: define SLV_BURST_CNT_EN to add a saturating completed-write counter.
module axi_stream_slave_mem
  import axi_stream_slave_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi_stream_slave_mem_if.slave  bus
`ifdef SLV_BURST_CNT_EN
  ,
  output logic [7:0]             wr_burst_cnt
`endif
);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              we;
  logic              last;

  assign last = (cnt == CNT_W'(BURST_LEN - 1));

  assign bus.ar_ready = (state == IDLE);
  assign bus.aw_ready = (state == IDLE) & ~bus.ar_valid;
  assign bus.r_valid  = (state == RD_DATA);
  assign bus.w_ready  = (state == WR_DATA);
  assign bus.b_valid  = (state == WR_RESP);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    we        = 1'b0;
    case (state)
      IDLE: begin
        // Read has priority; aw_ready is already low whenever ar_valid is high.
        if (bus.ar_valid) begin
          ptr_nxt   = bus.ar_addr;
          cnt_nxt   = '0;
          state_nxt = RD_DATA;
        end else if (bus.aw_valid) begin
          ptr_nxt   = bus.aw_addr;
          cnt_nxt   = '0;
          state_nxt = WR_DATA;
        end
      end
      RD_DATA: begin
        if (bus.r_ready) begin
          ptr_nxt = ptr + 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (last) state_nxt = IDLE;
        end
      end
      WR_DATA: begin
        if (bus.w_valid) begin
          we      = 1'b1;
          ptr_nxt = ptr + 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (last) state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bus.b_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  slv_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst_n),
    .we    (we),
    .addr  (ptr),
    .wdata (bus.w_data),
    .rdata (bus.r_data)
  );

`ifdef SLV_BURST_CNT_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_burst_cnt <= '0;
    end else if (bus.b_valid && bus.b_ready && wr_burst_cnt != 8'hFF) begin
      wr_burst_cnt <= wr_burst_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axi_stream_slave_mem.sv
// Scoreboard bench for axi_stream_slave_mem; reads are checked against a model memory.
module tb_axi_stream_slave_mem;
  logic clk;
  logic rst_n;

  axi_stream_slave_mem_if bus ();

`ifdef SLV_BURST_CNT_EN
  logic [7:0] wr_burst_cnt;
  int         n_bursts;
`endif

  axi_stream_slave_mem dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus)
`ifdef SLV_BURST_CNT_EN
    ,
    .wr_burst_cnt (wr_burst_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] model_mem [8];
  logic [3:0] exp_q [$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (model_mem[i]) model_mem[i] = 4'h0;
`ifdef SLV_BURST_CNT_EN
    n_bursts = 0;
`endif
    check("rst_ar_ready", bus.ar_ready, 1);
    check("rst_aw_ready", bus.aw_ready, 1);
    check("rst_r_valid",  bus.r_valid,  0);
    check("rst_w_ready",  bus.w_ready,  0);
    check("rst_b_valid",  bus.b_valid,  0);
    check("rst_r_data",   bus.r_data,   0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("post_rst_b_valid", bus.b_valid, 0);
`ifdef SLV_BURST_CNT_EN
    check("rst_burst_cnt", wr_burst_cnt, 0);
`endif
  endtask

  task automatic addr_rd(input logic [2:0] a);
    int budget = 20;
    logic [2:0] p = a;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(model_mem[p]);
      p = p + 3'd1;
    end
    bus.ar_valid = 1'b1;
    bus.ar_addr  = a;
    #1;
    while (!bus.ar_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("ar_wait", (budget > 0), 1);
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
    check("r_valid_lat", bus.r_valid, 1);
  endtask

  task automatic rd_beats(input logic [3:0] pattern);
    int budget = 100;
    int k = 0;
    while (exp_q.size() > 0 && budget > 0) begin
      bus.r_ready = pattern[k % 4];
      k++;
      #1;
      check("aw_blocked", bus.aw_ready, 0);
      if (bus.r_valid && bus.r_ready) check("r_data", bus.r_data, exp_q.pop_front());
      else if (bus.r_valid) check("r_hold", bus.r_data, exp_q[0]);
      else check("r_valid_drop", bus.r_valid, 1);
      @(posedge clk); #1;
      budget--;
    end
    bus.r_ready = 1'b0;
    check("rd_budget", (budget > 0), 1);
    check("rd_end_r_valid", bus.r_valid, 0);
    check("rd_end_ar_ready", bus.ar_ready, 1);
    exp_q.delete();
  endtask

  task automatic addr_wr(input logic [2:0] a);
    int budget = 40;
    bus.aw_valid = 1'b1;
    bus.aw_addr  = a;
    #1;
    while (!bus.aw_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("aw_wait", (budget > 0), 1);
    @(posedge clk); #1;
    bus.aw_valid = 1'b0;
    check("w_ready_lat", bus.w_ready, 1);
  endtask

  task automatic wr_beats(input logic [2:0] a, input int start, input int step,
                          input int n, input logic [3:0] gaps);
    int budget = 100;
    int i = 0;
    int k = 0;
    logic [2:0] p = a;
    while (i < n && budget > 0) begin
      bus.w_valid = gaps[k % 4];
      bus.w_data  = 4'(start + step * i);
      k++;
      #1;
      if (bus.w_valid && bus.w_ready) begin
        model_mem[p] = bus.w_data;
        p = p + 3'd1;
        i++;
      end
      @(posedge clk); #1;
      budget--;
    end
    bus.w_valid = 1'b0;
    check("wr_budget", (budget > 0), 1);
  endtask

  task automatic wr_resp();
    check("b_valid_lat", bus.b_valid, 1);
    check("resp_w_ready", bus.w_ready, 0);
    @(posedge clk); #1;
    check("b_valid_hold", bus.b_valid, 1);
    bus.b_ready = 1'b1;
    @(posedge clk); #1;
    bus.b_ready = 1'b0;
    check("b_valid_clear", bus.b_valid, 0);
    check("resp_ar_ready", bus.ar_ready, 1);
`ifdef SLV_BURST_CNT_EN
    n_bursts++;
    check("burst_cnt", wr_burst_cnt, 8'(n_bursts));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.ar_valid = 1'b0;
    bus.ar_addr  = '0;
    bus.r_ready  = 1'b0;
    bus.aw_valid = 1'b0;
    bus.aw_addr  = '0;
    bus.w_valid  = 1'b0;
    bus.w_data   = '0;
    bus.b_ready  = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset contents read back as zero
    addr_rd(3'd0);
    rd_beats(4'b1111);

    // b_ready outside WR_RESP is ignored
    bus.b_ready = 1'b1;
    @(posedge clk); #1;
    bus.b_ready = 1'b0;
    check("stray_b_ready", bus.b_valid, 0);

    // Full write then read: 1,3,...,15
    addr_wr(3'd0);
    wr_beats(3'd0, 1, 2, 8, 4'b1111);
    wr_resp();
    addr_rd(3'd0);
    rd_beats(4'b1111);

    // Wrap-around from 5 with w_valid gaps
    addr_wr(3'd5);
    wr_beats(3'd5, 0, 2, 8, 4'b1011);
    wr_resp();
    addr_rd(3'd5);
    rd_beats(4'b1111);
    addr_rd(3'd0);
    rd_beats(4'b1001);

    // Simultaneous ar/aw: read first, write on first idle cycle after
    bus.aw_valid = 1'b1;
    bus.aw_addr  = 3'd3;
    bus.ar_valid = 1'b1;
    bus.ar_addr  = 3'd2;
    #1;
    check("arb_aw_ready", bus.aw_ready, 0);
    addr_rd(3'd2);
    rd_beats(4'b1101);
    check("arb_aw_after", bus.aw_ready, 1);
    addr_wr(3'd3);
    wr_beats(3'd3, 7, 3, 8, 4'b1111);
    wr_resp();
    addr_rd(3'd1);
    rd_beats(4'b1111);

    // Abort a write after three beats
    addr_wr(3'd2);
    wr_beats(3'd2, 5, 1, 3, 4'b1111);
    do_reset();
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_b_valid", bus.b_valid, 0);
    end
    addr_rd(3'd0);
    rd_beats(4'b1111);

    // Two complete writes after reset
    addr_wr(3'd4);
    wr_beats(3'd4, 2, 5, 8, 4'b1111);
    wr_resp();
    addr_wr(3'd6);
    wr_beats(3'd6, 9, 1, 8, 4'b0111);
    wr_resp();
    addr_rd(3'd4);
    rd_beats(4'b1001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
